// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects operands over two ENTER presses, waits for the
// external add/two's-complement path to settle, then converts its magnitude to BCD.
module calc_sequencer #(
  parameter int DATA_W        = 4,
  parameter int BIN_W         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter_btn,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              op_sel,
  output logic [DATA_W-1:0] calc_a,
  output logic [DATA_W-1:0] calc_b,
  output logic              calc_op,
  input  logic [BIN_W-1:0]  conv_bin,
  input  logic              conv_neg,
  output logic [3:0]        bcd_hund,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones,
  output logic              neg_disp,
  output logic              busy,
  output logic              result_valid,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    SETTLE  = 3'd2,
    CONVERT = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam int SR_W   = 12 + BIN_W;
  localparam int ITER_W = $clog2(BIN_W + 1);

  state_t            state;
  state_t            state_next;
  logic              enter_q;
  logic              press;
  logic [3:0]        settle_cnt;
  logic [ITER_W-1:0] iter_cnt;
  logic [SR_W-1:0]   shift_reg;
  logic [SR_W-1:0]   shift_adj;
  logic              neg_lat;
  logic              fresh;
  logic              settle_done;
  logic              conv_done;

  assign press       = enter_btn & ~enter_q;
  assign settle_done = (settle_cnt == 4'(SETTLE_CYCLES - 1));
  assign conv_done   = (iter_cnt == ITER_W'(BIN_W - 1));
  assign busy        = (state == SETTLE) || (state == CONVERT);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_A;
    else       state <= state_next;
  end

  always_comb begin
    state_next = WAIT_A;
    case (state)
      WAIT_A:  state_next = press ? WAIT_B : WAIT_A;
      WAIT_B:  state_next = press ? SETTLE : WAIT_B;
      SETTLE:  state_next = settle_done ? CONVERT : SETTLE;
      CONVERT: state_next = conv_done ? SHOW : CONVERT;
      SHOW:    state_next = press ? WAIT_B : SHOW;
      default: state_next = WAIT_A;
    endcase
  end

  // Shift-add-3: any BCD nibble of 5 or more is corrected before the shift
  always_comb begin
    shift_adj = shift_reg;
    for (int i = 0; i < 3; i++) begin
      if (shift_reg[BIN_W + 4*i +: 4] >= 4'd5)
        shift_adj[BIN_W + 4*i +: 4] = shift_reg[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enter_q      <= 1'b1;
      calc_a       <= '0;
      calc_b       <= '0;
      calc_op      <= 1'b1;
      settle_cnt   <= '0;
      iter_cnt     <= '0;
      shift_reg    <= '0;
      neg_lat      <= 1'b0;
      fresh        <= 1'b0;
      bcd_hund     <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
      neg_disp     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      enter_q      <= enter_btn;
      result_valid <= 1'b0;
      case (state)
        WAIT_A: begin
          if (press) calc_a <= sw_data;
        end
        WAIT_B: begin
          if (press) begin
            calc_b     <= sw_data;
            calc_op    <= op_sel;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_done) begin
            shift_reg <= {12'b0, conv_bin};
            // A zero magnitude never shows a minus sign
            neg_lat   <= conv_neg & (|conv_bin);
            iter_cnt  <= '0;
          end
        end
        CONVERT: begin
          shift_reg <= shift_adj << 1;
          iter_cnt  <= iter_cnt + ITER_W'(1);
          if (conv_done) fresh <= 1'b1;
        end
        SHOW: begin
          if (fresh) begin
            bcd_hund     <= shift_reg[BIN_W + 8 +: 4];
            bcd_tens     <= shift_reg[BIN_W + 4 +: 4];
            bcd_ones     <= shift_reg[BIN_W +: 4];
            neg_disp     <= neg_lat;
            result_valid <= 1'b1;
            fresh        <= 1'b0;
          end
          if (press) calc_a <= sw_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural add/two's-complement
// stage closing the loop from calc_a/calc_b/calc_op back to conv_bin/conv_neg.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter_btn;
  logic [3:0] sw_data;
  logic       op_sel;
  logic [3:0] calc_a;
  logic [3:0] calc_b;
  logic       calc_op;
  logic [7:0] conv_bin;
  logic       conv_neg;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       neg_disp;
  logic       busy;
  logic       result_valid;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(.DATA_W(4), .BIN_W(8), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enter_btn(enter_btn), .sw_data(sw_data),
    .op_sel(op_sel), .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op),
    .conv_bin(conv_bin), .conv_neg(conv_neg), .bcd_hund(bcd_hund),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .neg_disp(neg_disp),
    .busy(busy), .result_valid(result_valid), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Existing adder plus two's-complement stage: unsigned magnitude and sign
  always_comb begin
    conv_neg = 1'b0;
    if (calc_op)
      conv_bin = {4'b0, calc_a} + {4'b0, calc_b};
    else if (calc_a >= calc_b)
      conv_bin = {4'b0, calc_a} - {4'b0, calc_b};
    else begin
      conv_bin = {4'b0, calc_b} - {4'b0, calc_a};
      conv_neg = 1'b1;
    end
  end

  task automatic press(input logic [3:0] d, input logic op);
    sw_data   = d;
    op_sel    = op;
    enter_btn = 1'b1;
    @(posedge clk); #1;
    enter_btn = 1'b0;
  endtask

  // Returns just after E0, the edge that samples the B press
  task automatic enter_operands(input logic [3:0] a, input logic [3:0] b, input logic op);
    press(a, 1'b1);
    @(posedge clk); #1;
    press(b, op);
  endtask

  task automatic run_to_result(input logic [3:0] ea, input logic [3:0] eb, input logic eop,
                               output int lat, output int busy_n, output int rv_n,
                               output int hold_bad);
    lat = 0; rv_n = 0; hold_bad = 0;
    busy_n = busy ? 1 : 0;
    for (int k = 1; k <= 14; k++) begin
      if ({calc_a, calc_b, calc_op} !== {ea, eb, eop}) hold_bad++;
      @(posedge clk); #1;
      if (busy) busy_n++;
      if (result_valid) begin
        rv_n++;
        if (lat == 0) lat = k;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enter_btn = 1'b0; sw_data = 4'd0; op_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({state_dbg, calc_a, calc_b, calc_op} !== {3'd0, 4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got state=%0d a=%0d b=%0d op=%0b want 0 0 0 1",
               state_dbg, calc_a, calc_b, calc_op);
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp, busy, result_valid} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL reset_disp got %0d%0d%0d neg=%0b busy=%0b rv=%0b want all 0",
               bcd_hund, bcd_tens, bcd_ones, neg_disp, busy, result_valid);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat, busy_n, rv_n, hold_bad;
    enter_operands(4'd7, 4'd5, 1'b1);
    run_to_result(4'd7, 4'd5, 1'b1, lat, busy_n, rv_n, hold_bad);
    checks++;
    if (lat !== 11) begin
      errors++; $display("[TB] FAIL add_latency got %0d want 11", lat);
    end
    checks++;
    if (busy_n !== 10) begin
      errors++; $display("[TB] FAIL add_busy_cycles got %0d want 10", busy_n);
    end
    checks++;
    if (rv_n !== 1) begin
      errors++; $display("[TB] FAIL add_valid_pulses got %0d want 1", rv_n);
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp} !== {4'd0, 4'd1, 4'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_digits got %0d%0d%0d neg=%0b want 012 neg=0",
               bcd_hund, bcd_tens, bcd_ones, neg_disp);
    end
    checks++;
    if (state_dbg !== 3'd4) begin
      errors++; $display("[TB] FAIL add_show_state got %0d want 4", state_dbg);
    end
  endtask

  task automatic test_sub_negative();
    int lat, busy_n, rv_n, hold_bad;
    enter_operands(4'd3, 4'd9, 1'b0);
    run_to_result(4'd3, 4'd9, 1'b0, lat, busy_n, rv_n, hold_bad);
    checks++;
    if (hold_bad !== 0) begin
      errors++; $display("[TB] FAIL sub_operand_hold got %0d changed cycles want 0", hold_bad);
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp, rv_n} !== {4'd0, 4'd0, 4'd6, 1'b1, 32'd1}) begin
      errors++;
      $display("[TB] FAIL sub_digits got %0d%0d%0d neg=%0b pulses=%0d want 006 neg=1 pulses=1",
               bcd_hund, bcd_tens, bcd_ones, neg_disp, rv_n);
    end
  endtask

  task automatic test_add_max();
    int lat, busy_n, rv_n, hold_bad;
    enter_operands(4'd15, 4'd15, 1'b1);
    run_to_result(4'd15, 4'd15, 1'b1, lat, busy_n, rv_n, hold_bad);
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp} !== {4'd0, 4'd3, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL max_digits got %0d%0d%0d neg=%0b want 030 neg=0",
               bcd_hund, bcd_tens, bcd_ones, neg_disp);
    end
  endtask

  task automatic test_zero_and_chain();
    int lat, busy_n, rv_n, hold_bad;
    enter_operands(4'd5, 4'd5, 1'b0);
    run_to_result(4'd5, 4'd5, 1'b0, lat, busy_n, rv_n, hold_bad);
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp, lat} !== {4'd0, 4'd0, 4'd0, 1'b0, 32'd11}) begin
      errors++;
      $display("[TB] FAIL zero_digits got %0d%0d%0d neg=%0b lat=%0d want 000 neg=0 lat=11",
               bcd_hund, bcd_tens, bcd_ones, neg_disp, lat);
    end
    press(4'd4, 1'b1);
    checks++;
    if ({state_dbg, calc_a, bcd_hund, bcd_tens, bcd_ones, result_valid} !==
        {3'd1, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL chain_entry got state=%0d a=%0d digits=%0d%0d%0d rv=%0b want 1 4 000 0",
               state_dbg, calc_a, bcd_hund, bcd_tens, bcd_ones, result_valid);
    end
    @(posedge clk); #1;
    press(4'd2, 1'b1);
    run_to_result(4'd4, 4'd2, 1'b1, lat, busy_n, rv_n, hold_bad);
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp, lat} !== {4'd0, 4'd0, 4'd6, 1'b0, 32'd11}) begin
      errors++;
      $display("[TB] FAIL chain_digits got %0d%0d%0d neg=%0b lat=%0d want 006 neg=0 lat=11",
               bcd_hund, bcd_tens, bcd_ones, neg_disp, lat);
    end
  endtask

  task automatic test_enter_ignored();
    int lat = 0;
    int bad_state = 0;
    logic [2:0] exp_state;
    enter_operands(4'd2, 4'd9, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      enter_btn = (k <= 8) && (k % 2 == 1);
      @(posedge clk); #1;
      exp_state = (k < 2) ? 3'd2 : (k < 10) ? 3'd3 : 3'd4;
      if (state_dbg !== exp_state) bad_state++;
      if (result_valid && lat == 0) lat = k;
    end
    enter_btn = 1'b0;
    checks++;
    if (bad_state !== 0) begin
      errors++; $display("[TB] FAIL busy_press_state got %0d wrong cycles want 0", bad_state);
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp, lat} !== {4'd0, 4'd0, 4'd7, 1'b1, 32'd11}) begin
      errors++;
      $display("[TB] FAIL busy_press_digits got %0d%0d%0d neg=%0b lat=%0d want 007 neg=1 lat=11",
               bcd_hund, bcd_tens, bcd_ones, neg_disp, lat);
    end
  endtask

  task automatic test_held_enter();
    int lat, busy_n, rv_n, hold_bad;
    sw_data = 4'd6;
    enter_btn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({state_dbg, calc_a} !== {3'd1, 4'd6}) begin
      errors++;
      $display("[TB] FAIL held_single_press got state=%0d a=%0d want 1 6", state_dbg, calc_a);
    end
    enter_btn = 1'b0;
    @(posedge clk); #1;
    press(4'd1, 1'b0);
    run_to_result(4'd6, 4'd1, 1'b0, lat, busy_n, rv_n, hold_bad);
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp} !== {4'd0, 4'd0, 4'd5, 1'b0}) begin
      errors++;
      $display("[TB] FAIL held_digits got %0d%0d%0d neg=%0b want 005 neg=0",
               bcd_hund, bcd_tens, bcd_ones, neg_disp);
    end
  endtask

  task automatic test_reset_abort();
    int rv_n = 0;
    int left_wait_a = 0;
    enter_operands(4'd9, 4'd4, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    enter_btn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({state_dbg, calc_a, calc_b, calc_op, busy, result_valid} !== {3'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL abort_ctrl got state=%0d a=%0d b=%0d op=%0b busy=%0b rv=%0b want 0 0 0 1 0 0",
               state_dbg, calc_a, calc_b, calc_op, busy, result_valid);
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, neg_disp} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL abort_disp got %0d%0d%0d neg=%0b want 000 neg=0",
               bcd_hund, bcd_tens, bcd_ones, neg_disp);
    end
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (result_valid) rv_n++;
      if (state_dbg !== 3'd0) left_wait_a++;
    end
    checks++;
    if ({rv_n, left_wait_a} !== {32'd0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL abort_held_enter got pulses=%0d non_wait_a=%0d want 0 0", rv_n, left_wait_a);
    end
    enter_btn = 1'b0;
    @(posedge clk); #1;
    press(4'd11, 1'b1);
    checks++;
    if ({state_dbg, calc_a} !== {3'd1, 4'd11}) begin
      errors++;
      $display("[TB] FAIL abort_repress got state=%0d a=%0d want 1 11", state_dbg, calc_a);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_negative();
    test_add_max();
    test_zero_and_chain();
    test_enter_ignored();
    test_held_enter();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Top-level controller for the 4-bit add/subtract calculator.
- Collects operand A, operand B and the operation from the switches over two ENTER presses, then drives them to the existing adder and two's-complement stage.
- After a settle window it captures the unsigned magnitude and negative flag from that stage and runs an iterative shift-add-3 binary-to-BCD conversion.
- Holds three BCD digits plus a sign for the seven-segment display driver.

Parameters:
- DATA_W, 4, operand width driven to the adder.
- BIN_W, 8, width of the magnitude returned by the two's-complement stage; equals the BCD conversion iteration count.
- SETTLE_CYCLES, 2, cycles allowed for the combinational adder and two's-complement path to settle; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enter_btn  input  1  debounced ENTER push-button, level.
- sw_data  input  DATA_W  operand switches.
- op_sel  input  1  1 = add, 0 = subtract (same encoding as OP1).
- calc_a  output  DATA_W  latched operand A to the adder.
- calc_b  output  DATA_W  latched operand B to the adder.
- calc_op  output  1  latched operation to the adder and the two's-complement stage.
- conv_bin  input  BIN_W  magnitude from the two's-complement stage.
- conv_neg  input  1  negative flag from the two's-complement stage.
- bcd_hund  output  4  hundreds digit.
- bcd_tens  output  4  tens digit.
- bcd_ones  output  4  ones digit.
- neg_disp  output  1  sign for the display.
- busy  output  1  high in SETTLE and CONVERT.
- result_valid  output  1  one-cycle pulse when new digits are written.
- state_dbg  output  3  current state encoding.

Behaviour:
- Press detection:
  - enter_q registers enter_btn every cycle.
  - press = enter_btn & ~enter_q.
  - enter_q resets to 1, so a button held through reset does not register as a press.
- Reset values:
  - State WAIT_A.
  - calc_a, calc_b, calc_op = 0, 0, 1.
  - All BCD digits 0, neg_disp 0, busy 0, result_valid 0.
  - Settle counter, iteration counter and shift register all 0.
- States and encoding: WAIT_A=0, WAIT_B=1, SETTLE=2, CONVERT=3, SHOW=4. Codes 5–7 go to WAIT_A.
- WAIT_A: on press, calc_a <= sw_data, next state WAIT_B.
- WAIT_B: on press, calc_b <= sw_data, calc_op <= op_sel, settle counter <= 0, next state SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - On the cycle the counter equals SETTLE_CYCLES-1: load shift register {12'b0, conv_bin}, latch conv_neg internally, clear iteration counter, next state CONVERT.
- CONVERT:
  - Each cycle, every 4-bit BCD nibble ≥ 5 gets +3, then the whole {bcd[11:0], bin[BIN_W-1:0]} register shifts left by 1.
  - After exactly BIN_W iterations, next state SHOW.
- Entering SHOW, on the next edge:
  - bcd_hund/tens/ones <= BCD nibbles and neg_disp <= latched sign.
  - result_valid = 1 for exactly that cycle.
  - If the magnitude is 0, force neg_disp = 0.
- SHOW: digits are held. On press, calc_a <= sw_data, next state WAIT_B (chained entry). Display outputs keep the old result until the next result is written.
- Presses while in SETTLE or CONVERT are ignored and not queued.
- Latency: take the edge that samples the B press as E0. Digits update and result_valid is high after edge E0 + SETTLE_CYCLES + BIN_W + 1 (edge 11 with defaults).
- calc_a, calc_b and calc_op stay stable from the B press until the next accepted press; the datapath inputs never change during SETTLE or CONVERT.
- Reset in any state aborts immediately: all outputs return to reset values on that edge and any in-flight result is discarded.
- The block does no arithmetic on operands; all sign and overflow handling stays in the existing two's-complement stage.

Test Plan:
- Bench contents: the existing adder and two's-complement stage in the loop, with a behavioural 4-bit add/sub model as cross-check.
- A=7, B=5, op_sel=1 -> after E0+11: digits 0,1,2, neg_disp=0, one-cycle result_valid, busy high for exactly 10 cycles.
- A=3, B=9, op_sel=0 -> digits 0,0,6, neg_disp=1; calc_a=3, calc_b=9, calc_op=0 held through CONVERT.
- A=15, B=15, op_sel=1 -> digits 0,3,0, neg_disp=0.
- A=5, B=5, op_sel=0 -> digits 0,0,0, neg_disp=0. Then a press in SHOW with sw_data=4 -> calc_a=4, state WAIT_B, and digits stay 0,0,0.
- ENTER toggled during SETTLE and CONVERT -> no state change and result identical to the undisturbed run. ENTER held high for 20 cycles -> exactly one press.
- Reset asserted on the 3rd CONVERT cycle -> all outputs return to reset values on that edge and no result_valid follows. ENTER held high across reset release -> stays in WAIT_A until released and pressed again.
